// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage RV32 pipeline
//
// Combines load-use stall, EX branch-taken, EX trap and the data-memory
// handshake into write enables and flushes for PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB. Owns the memory-wait timeout and the trap drain sequence.
//
// Optional feature: define PIPE_CTRL_PERF_EN to build the stall counter;
// otherwise stall_cnt_o is tied to 0.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   load_use_i                 load-use stall request
//   branch_taken_i             branch/jump resolved taken in EX
//   trap_i                     trap raised by the EX instruction
//   mem_req_i, dmem_ready_i    MEM stage access / data memory completion
//   pc_we_o, pc_sel_trap_o     PC write enable, select trap vector
//   ifid/idex/exmem_we_o       pipeline register write enables
//   ifid/idex/exmem_flush_o    load a NOP bubble into that register
//   memwb_bubble_o             MEM/WB captures a bubble
//   mem_err_o                  one-cycle pulse on memory timeout
//   state_o                    RUN=0, MEM_WAIT=1, TRAP_FLUSH=2
//   stall_cnt_o                saturating count of cycles with pc_we_o=0

module pipeline_ctrl #(
    parameter int MEM_TIMEOUT  = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_i,
    input  logic             branch_taken_i,
    input  logic             trap_i,
    input  logic             mem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_we_o,
    output logic             pc_sel_trap_o,
    output logic             ifid_we_o,
    output logic             idex_we_o,
    output logic             exmem_we_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic             memwb_bubble_o,
    output logic             mem_err_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        TRAP_FLUSH = 2'd2
    } state_t;

    localparam logic [7:0] WCNT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [2:0] FCNT_LAST = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_next;
    logic [7:0] wcnt, wcnt_next;
    logic [2:0] fcnt, fcnt_next;

    // RUN-priority evaluation is shared between RUN and the MEM_WAIT exit
    // cycle; freeze_en is cleared on the exit cycle so the stale wait does
    // not re-freeze the pipe.
    logic eval_run;
    logic freeze_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            wcnt  <= '0;
            fcnt  <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
            fcnt  <= fcnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        wcnt_next      = wcnt;
        fcnt_next      = fcnt;
        eval_run       = 1'b0;
        freeze_en      = 1'b0;
        pc_we_o        = 1'b1;
        pc_sel_trap_o  = 1'b0;
        ifid_we_o      = 1'b1;
        idex_we_o      = 1'b1;
        exmem_we_o     = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_flush_o   = 1'b0;
        exmem_flush_o  = 1'b0;
        memwb_bubble_o = 1'b0;
        mem_err_o      = 1'b0;

        case (state)
            RUN: begin
                eval_run  = 1'b1;
                freeze_en = 1'b1;
            end
            MEM_WAIT: begin
                if (dmem_ready_i) begin
                    eval_run = 1'b1;
                end else begin
                    pc_we_o        = 1'b0;
                    ifid_we_o      = 1'b0;
                    idex_we_o      = 1'b0;
                    exmem_we_o     = 1'b0;
                    memwb_bubble_o = 1'b1;
                    if (wcnt == WCNT_LAST) begin
                        mem_err_o  = 1'b1;
                        state_next = TRAP_FLUSH;
                        fcnt_next  = '0;
                    end else begin
                        wcnt_next = wcnt + 8'd1;
                    end
                end
            end
            TRAP_FLUSH: begin
                pc_we_o       = 1'b0;
                ifid_flush_o  = 1'b1;
                idex_flush_o  = 1'b1;
                exmem_flush_o = 1'b1;
                if (fcnt == FCNT_LAST) begin
                    pc_we_o       = 1'b1;
                    pc_sel_trap_o = 1'b1;
                    state_next    = RUN;
                end else begin
                    fcnt_next = fcnt + 3'd1;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase

        if (eval_run) begin
            state_next = RUN;
            if (freeze_en && mem_req_i && !dmem_ready_i) begin
                pc_we_o        = 1'b0;
                ifid_we_o      = 1'b0;
                idex_we_o      = 1'b0;
                exmem_we_o     = 1'b0;
                memwb_bubble_o = 1'b1;
                state_next     = MEM_WAIT;
                wcnt_next      = '0;
            end else if (trap_i) begin
                pc_we_o       = 1'b0;
                ifid_flush_o  = 1'b1;
                idex_flush_o  = 1'b1;
                exmem_flush_o = 1'b1;
                state_next    = TRAP_FLUSH;
                fcnt_next     = '0;
            end else if (branch_taken_i) begin
                // Wins over load-use: the ID instruction is on the wrong path.
                pc_we_o      = 1'b1;
                ifid_flush_o = 1'b1;
                idex_flush_o = 1'b1;
            end else if (load_use_i) begin
                pc_we_o      = 1'b0;
                ifid_we_o    = 1'b0;
                idex_flush_o = 1'b1;
            end
        end

        // Reset forces a fully bubbled, frozen pipe regardless of state.
        if (!rst_n) begin
            pc_we_o        = 1'b0;
            pc_sel_trap_o  = 1'b0;
            ifid_we_o      = 1'b0;
            idex_we_o      = 1'b0;
            exmem_we_o     = 1'b0;
            ifid_flush_o   = 1'b1;
            idex_flush_o   = 1'b1;
            exmem_flush_o  = 1'b1;
            memwb_bubble_o = 1'b1;
            mem_err_o      = 1'b0;
        end
    end

    assign state_o = state;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!pc_we_o && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl

module tb_pipeline_ctrl;

    localparam int CNT_W = 16;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Expected output vector layout:
    // {pc_we, pc_sel_trap, ifid_we, idex_we, exmem_we,
    //  ifid_flush, idex_flush, exmem_flush, memwb_bubble, mem_err}
    localparam logic [9:0] V_RST    = 10'b0000011110;
    localparam logic [9:0] V_IDLE   = 10'b1011100000;
    localparam logic [9:0] V_LU     = 10'b0001101000;
    localparam logic [9:0] V_BR     = 10'b1011111000;
    localparam logic [9:0] V_FRZ    = 10'b0000000010;
    localparam logic [9:0] V_FRZERR = 10'b0000000011;
    localparam logic [9:0] V_TRAP   = 10'b0011111100;
    localparam logic [9:0] V_VEC    = 10'b1111111100;

    logic clk = 1'b0;
    logic rst_n, load_use, branch_taken, trap, mem_req, dmem_ready;
    logic pc_we, pc_sel_trap, ifid_we, idex_we, exmem_we;
    logic ifid_flush, idex_flush, exmem_flush, memwb_bubble, mem_err;
    logic [1:0] state;
    logic [CNT_W-1:0] stall_cnt;

    int total = 0;
    int bad = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MEM_TIMEOUT(16), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .load_use_i(load_use),
        .branch_taken_i(branch_taken), .trap_i(trap), .mem_req_i(mem_req),
        .dmem_ready_i(dmem_ready), .pc_we_o(pc_we), .pc_sel_trap_o(pc_sel_trap),
        .ifid_we_o(ifid_we), .idex_we_o(idex_we), .exmem_we_o(exmem_we),
        .ifid_flush_o(ifid_flush), .idex_flush_o(idex_flush),
        .exmem_flush_o(exmem_flush), .memwb_bubble_o(memwb_bubble),
        .mem_err_o(mem_err), .state_o(state), .stall_cnt_o(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check the
    // settled outputs before the next rising edge, then advance the model.
    task automatic step(input logic r, input logic lu, input logic br, input logic tr,
                        input logic mr, input logic dr, input logic [9:0] ev,
                        input logic [1:0] es, input string tag);
        @(negedge clk);
        rst_n = r; load_use = lu; branch_taken = br; trap = tr;
        mem_req = mr; dmem_ready = dr;
        #1;
        chk({tag, "_outs"}, 32'({pc_we, pc_sel_trap, ifid_we, idex_we, exmem_we,
                                 ifid_flush, idex_flush, exmem_flush, memwb_bubble, mem_err}),
            32'(ev));
        chk({tag, "_state"}, 32'(state), 32'(es));
        chk({tag, "_cnt"}, 32'(stall_cnt), 32'(exp_cnt));
        if (!r) exp_cnt = '0;
        else if (PERF && !ev[9] && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; load_use = 1'b0; branch_taken = 1'b0; trap = 1'b0;
        mem_req = 1'b0; dmem_ready = 1'b0;

        // Reset and release
        step(0, 0, 0, 0, 0, 0, V_RST,  2'd0, "rst0");
        step(0, 0, 0, 0, 0, 0, V_RST,  2'd0, "rst1");
        step(1, 0, 0, 0, 0, 0, V_IDLE, 2'd0, "idle0");
        step(1, 0, 0, 0, 0, 0, V_IDLE, 2'd0, "idle1");

        // Load-use single cycle, then counter shows one stall
        step(1, 1, 0, 0, 0, 0, V_LU,   2'd0, "loaduse");
        step(1, 0, 0, 0, 0, 0, V_IDLE, 2'd0, "after_lu");

        // Branch beats load-use
        step(1, 1, 1, 0, 0, 0, V_BR,   2'd0, "br_lu");

        // Memory wait of three frozen cycles, exit with branch
        step(1, 0, 0, 0, 1, 0, V_FRZ,  2'd0, "mw_enter");
        step(1, 0, 1, 0, 1, 0, V_FRZ,  2'd1, "mw_1");
        step(1, 1, 1, 1, 1, 0, V_FRZ,  2'd1, "mw_2");
        step(1, 0, 1, 0, 1, 1, V_BR,   2'd1, "mw_exit_br");
        step(1, 0, 0, 0, 0, 0, V_IDLE, 2'd0, "mw_done");

        // Memory timeout: error on the 16th cycle after the detecting cycle
        step(1, 0, 0, 0, 1, 0, V_FRZ,  2'd0, "to_enter");
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 0, 0, 1, 0, (i == 16) ? V_FRZERR : V_FRZ, 2'd1, $sformatf("to_w%0d", i));
        end
        step(1, 1, 1, 0, 1, 0, V_TRAP, 2'd2, "to_tf0");
        step(1, 0, 0, 0, 0, 0, V_VEC,  2'd2, "to_tf1");
        step(1, 0, 0, 0, 0, 0, V_IDLE, 2'd0, "to_done");

        // Memory wait exiting into a pending trap
        step(1, 0, 0, 1, 1, 0, V_FRZ,  2'd0, "mt_enter");
        step(1, 0, 0, 1, 1, 1, V_TRAP, 2'd1, "mt_exit_trap");
        step(1, 0, 0, 0, 0, 0, V_TRAP, 2'd2, "mt_tf0");
        step(1, 0, 0, 0, 0, 0, V_VEC,  2'd2, "mt_tf1");
        step(1, 0, 0, 0, 0, 0, V_IDLE, 2'd0, "mt_done");

        // Trap aborted by reset during TRAP_FLUSH
        step(1, 0, 0, 1, 0, 0, V_TRAP, 2'd0, "tr_raise");
        step(1, 0, 0, 0, 0, 0, V_TRAP, 2'd2, "tr_tf0");
        step(0, 0, 0, 0, 0, 0, V_RST,  2'd2, "tr_rst");
        step(0, 0, 0, 0, 0, 0, V_RST,  2'd0, "tr_rst_done");
        step(1, 0, 0, 0, 0, 0, V_IDLE, 2'd0, "tr_release");
        step(1, 0, 0, 0, 0, 0, V_IDLE, 2'd0, "tr_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RISC-V 32-bit pipeline. It combines the load-use stall from `hazard_detection_unit`, the EX-stage branch-taken signal, EX-stage traps and the data-memory handshake. From these it drives the write enables and flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also owns the data-memory wait timeout, the trap drain sequence and an optional stall performance counter.

## Interface
Parameters:
- `MEM_TIMEOUT`, 16: number of MEM_WAIT cycles before a bus-error trap (legal range 2..255).
- `FLUSH_CYCLES`, 2: length of the TRAP_FLUSH state in cycles (legal range 1..7).
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst_n`  in  1  reset. Synchronous and active-low.
- `load_use_i`  in  1  stall request from hazard_detection_unit.
- `branch_taken_i`  in  1  branch/jump resolved taken in EX.
- `trap_i`  in  1  trap raised by the instruction in EX (illegal, ecall).
- `mem_req_i`  in  1  MEM stage holds a valid load/store.
- `dmem_ready_i`  in  1  data memory completes the access this cycle.
- `pc_we_o`  out  1  PC register write enable.
- `pc_sel_trap_o`  out  1  selects the trap vector as next PC.
- `ifid_we_o`, `idex_we_o`, `exmem_we_o`  out  1 each  pipeline register write enables.
- `ifid_flush_o`, `idex_flush_o`, `exmem_flush_o`  out  1 each  load a NOP bubble into that register.
- `memwb_bubble_o`  out  1  MEM/WB captures a bubble (regWrite=0).
- `mem_err_o`  out  1  one-cycle pulse on memory timeout.
- `state_o`  out  2  current state: RUN=0, MEM_WAIT=1, TRAP_FLUSH=2.
- `stall_cnt_o`  out  CNT_W  saturating count of cycles with `pc_we_o=0`.

## Operation
- Default outputs: all `*_we_o`=1; all flushes, `memwb_bubble_o`, `pc_sel_trap_o` and `mem_err_o`=0.
- Outputs are Mealy in RUN and on the MEM_WAIT exit cycle, and Moore elsewhere.

RUN: inputs are evaluated in fixed priority, highest first.
1. `mem_req_i & ~dmem_ready_i` (freeze):
   - Freeze: `pc_we_o`, `ifid_we_o`, `idex_we_o` and `exmem_we_o` go to 0; `memwb_bubble_o`=1.
   - Next state MEM_WAIT; wait counter `wcnt` is cleared to 0.
2. `trap_i`:
   - `pc_we_o`=0; `ifid_flush_o`, `idex_flush_o` and `exmem_flush_o` go to 1.
   - Next state TRAP_FLUSH; flush counter `fcnt` is cleared to 0.
3. `branch_taken_i`:
   - `pc_we_o`=1; `ifid_flush_o` and `idex_flush_o` go to 1.
   - This beats load-use, because the ID instruction is on the wrong path.
4. `load_use_i`:
   - `pc_we_o` and `ifid_we_o` go to 0; `idex_flush_o`=1.
   - Stays in RUN.

MEM_WAIT:
- While `dmem_ready_i`=0, the freeze outputs are held and `wcnt` increments.
- If `wcnt==MEM_TIMEOUT-1` and the access is still not ready:
  - `mem_err_o`=1 for that cycle, with the freeze held.
  - Next state TRAP_FLUSH.
- When `dmem_ready_i`=1:
  - Outputs are computed exactly as in RUN with the freeze term forced false, so a pending trap, branch or load-use is honoured in that cycle.
  - Next state is whatever RUN would choose, otherwise RUN.
- `trap_i`, `branch_taken_i` and `load_use_i` are ignored while frozen. EX is frozen, so they persist until the exit cycle.

TRAP_FLUSH:
- All three flushes =1 and `pc_we_o`=0.
- On `fcnt==FLUSH_CYCLES-1`: `pc_we_o`=1, `pc_sel_trap_o`=1, next state RUN.
- Otherwise `fcnt` increments.
- All inputs are ignored in this state.

Reset:
- While `rst_n`=0: all `*_we_o`=0, all flushes=1, `memwb_bubble_o`=1, `pc_sel_trap_o`=0, `mem_err_o`=0.
- `state_o` is RUN; `wcnt`, `fcnt` and `stall_cnt_o` are 0.
- A reset asserted mid-MEM_WAIT or mid-TRAP_FLUSH aborts the sequence at the next edge.

## Timing
- Decisions in RUN take effect in the same cycle; there is zero latency from input to output.
- Trap: total `1+FLUSH_CYCLES` cycles from the trap cycle to the PC load of the vector.
- Memory timeout: `mem_err_o` pulses `MEM_TIMEOUT` cycles after the RUN cycle that detected the wait.
- `mem_err_o` is never high for two consecutive cycles.
- `stall_cnt_o` updates one cycle after each stalled cycle and saturates at all-ones.
- There is no wrap-around of `wcnt` or `fcnt`: both are bounded by their terminal compare.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: the `stall_cnt_o` counter is built.
- Not defined: no counter flops are built; `stall_cnt_o` is tied to 0 and all other behaviour is identical.

## Test plan
- Reset release with all inputs 0:
  - `state_o`=0, all enables 1, no flush.
  - `stall_cnt_o` stays 0.
- `load_use_i`=1 for one cycle:
  - That cycle: `pc_we_o`=0, `ifid_we_o`=0, `idex_flush_o`=1.
  - `stall_cnt_o` goes 0→1.
- `branch_taken_i`=1 with `load_use_i`=1:
  - `pc_we_o`=1, `ifid_flush_o`=1, `idex_flush_o`=1, `ifid_we_o`=1.
- `mem_req_i`=1 with `dmem_ready_i` low for 3 cycles, then high together with `branch_taken_i`=1:
  - 3 frozen cycles with `memwb_bubble_o`=1.
  - Exit cycle applies the branch flush.
  - `state_o` sequence is 0,1,1,1→0.
- `MEM_TIMEOUT`=16, `dmem_ready_i` never asserted:
  - `mem_err_o` pulses 16 cycles after entry.
  - Then 2 TRAP_FLUSH cycles; the last has `pc_sel_trap_o`=1 and `pc_we_o`=1.
- `trap_i`=1 followed by `rst_n`=0 during TRAP_FLUSH:
  - Next edge gives `state_o`=0 and `pc_sel_trap_o` never asserts.
